// File: rtl/feature_window_line_buffer_pkg.sv
// Shared sizing defaults and kernel-row encodings for the sliding-window line buffer.
`timescale 1ns/1ps
package feature_window_line_buffer_pkg;
    localparam int FEATURE_WIDTH = 16;
    localparam int PE_CORE_NUM   = 16;
    localparam int CH_NUM        = PE_CORE_NUM;
    localparam int MAX_K         = 5;
    localparam int COL_W         = 10;
    localparam int ROW_W         = 10;

    typedef enum logic [2:0] {
        KROWS_1 = 3'd1,
        KROWS_3 = 3'd3,
        KROWS_5 = 3'd5
    } kernel_rows_e;

    function automatic logic kernel_rows_legal(input logic [2:0] k, input int max_k);
        logic ok;
        case (k)
            KROWS_1: ok = 1'b1;
            KROWS_3: ok = (max_k >= 3);
            KROWS_5: ok = (max_k >= 5);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction
endpackage

// File: rtl/line_delay_ram.sv
// Circular delay line: reads the entry at the pointer and overwrites it in the same
// enabled cycle, so the read value is the word written `depth` enables earlier.
`timescale 1ns/1ps
module line_delay_ram #(
    parameter int WIDTH  = 256,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [ADDR_W-1:0] depth,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0]  mem_q [1 << ADDR_W];
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    // Pointer advance with wrap at depth-1; a frame start rewinds it.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = {ADDR_W{1'b0}};
        end else if (en) begin
            if (ptr_q == depth - {{(ADDR_W-1){1'b0}}, 1'b1}) begin
                ptr_d = {ADDR_W{1'b0}};
            end else begin
                ptr_d = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= {ADDR_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage is never cleared; priming rows overwrite whatever a previous frame left.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[ptr_q];
endmodule

// File: rtl/feature_window_line_buffer.sv
// K-row sliding-window line buffer: one multi-channel pixel in, one vertical column
// of kernel_rows taps per channel out, with priming suppression and row/frame flags.
`timescale 1ns/1ps
module feature_window_line_buffer #(
    parameter int FEATURE_WIDTH = feature_window_line_buffer_pkg::FEATURE_WIDTH,
    parameter int CH_NUM        = feature_window_line_buffer_pkg::CH_NUM,
    parameter int MAX_K         = feature_window_line_buffer_pkg::MAX_K,
    parameter int COL_W         = feature_window_line_buffer_pkg::COL_W,
    parameter int ROW_W         = feature_window_line_buffer_pkg::ROW_W
) (
    input  logic                                  system_clk,
    input  logic                                  rst_n,
    input  logic                                  cfg_start,
    input  logic [2:0]                            cfg_kernel_rows,
    input  logic [COL_W-1:0]                      cfg_col_size,
    input  logic [ROW_W-1:0]                      cfg_row_size,
    output logic                                  cfg_error,
    output logic                                  busy,
    input  logic [CH_NUM*FEATURE_WIDTH-1:0]       feature_in_data,
    input  logic                                  feature_in_valid,
    output logic                                  feature_in_ready,
    output logic [CH_NUM*MAX_K*FEATURE_WIDTH-1:0] window_data,
    output logic                                  window_valid,
    input  logic                                  window_ready,
    output logic                                  window_row_last,
    output logic                                  window_frame_last
);
    import feature_window_line_buffer_pkg::*;

    localparam int PW = CH_NUM * FEATURE_WIDTH;
    localparam int WW = CH_NUM * MAX_K * FEATURE_WIDTH;

    logic [2:0]       k_q;
    logic [COL_W-1:0] c_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] r_q;
    logic [ROW_W-1:0] row_q;
    logic             busy_q;
    logic             frame_done_q;
    logic             cfg_error_q;
    logic             win_valid_q;
    logic             row_last_q;
    logic             frame_last_q;
    logic [WW-1:0]    win_data_q;
    logic [WW-1:0]    win_data_d;

    logic             cfg_legal_s;
    logic             accept_s;
    logic             out_accept_s;
    logic             emit_s;
    logic             col_last_s;
    logic             row_last_s;
    logic [PW-1:0]    taps_s    [MAX_K];
    logic [PW-1:0]    rd_data_s [MAX_K-1];

    assign cfg_legal_s = kernel_rows_legal(cfg_kernel_rows, MAX_K)
                       && (cfg_col_size != {COL_W{1'b0}})
                       && (cfg_row_size >= ROW_W'(cfg_kernel_rows));

    assign feature_in_ready = busy_q & ~frame_done_q & (~win_valid_q | window_ready);
    // cfg_start wins over a beat presented in the same cycle.
    assign accept_s     = feature_in_valid & feature_in_ready & ~cfg_start;
    assign out_accept_s = win_valid_q & window_ready;
    assign col_last_s   = (col_q == c_q - {{(COL_W-1){1'b0}}, 1'b1});
    assign row_last_s   = (row_q == r_q - {{(ROW_W-1){1'b0}}, 1'b1});
    assign emit_s       = (row_q >= (ROW_W'(k_q) - {{(ROW_W-1){1'b0}}, 1'b1}));

    assign taps_s[0] = feature_in_data;

    for (genvar j = 0; j < MAX_K - 1; j++) begin : g_line
        line_delay_ram #(
            .WIDTH  (PW),
            .ADDR_W (COL_W)
        ) u_line (
            .clk     (system_clk),
            .rst_n   (rst_n),
            .clr     (cfg_start),
            .en      (accept_s),
            .depth   (c_q),
            .wr_data (taps_s[j]),
            .rd_data (rd_data_s[j])
        );
        assign taps_s[j+1] = rd_data_s[j];
    end

    // Pack taps per channel, zeroing rows beyond the configured kernel height.
    always_comb begin
        win_data_d = {WW{1'b0}};
        for (int c = 0; c < CH_NUM; c++) begin
            for (int j = 0; j < MAX_K; j++) begin
                win_data_d[(c*MAX_K+j)*FEATURE_WIDTH +: FEATURE_WIDTH] =
                    (j < int'(k_q)) ? taps_s[j][c*FEATURE_WIDTH +: FEATURE_WIDTH]
                                    : {FEATURE_WIDTH{1'b0}};
            end
        end
    end

    // Config latch, counters, handshake and output register.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q          <= 3'd0;
            c_q          <= {COL_W{1'b0}};
            r_q          <= {ROW_W{1'b0}};
            col_q        <= {COL_W{1'b0}};
            row_q        <= {ROW_W{1'b0}};
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_error_q  <= 1'b0;
            win_valid_q  <= 1'b0;
            row_last_q   <= 1'b0;
            frame_last_q <= 1'b0;
            win_data_q   <= {WW{1'b0}};
        end else begin
            cfg_error_q <= 1'b0;
            if (cfg_start) begin
                cfg_error_q  <= ~cfg_legal_s;
                busy_q       <= cfg_legal_s;
                frame_done_q <= 1'b0;
                win_valid_q  <= 1'b0;
                row_last_q   <= 1'b0;
                frame_last_q <= 1'b0;
                col_q        <= {COL_W{1'b0}};
                row_q        <= {ROW_W{1'b0}};
                if (cfg_legal_s) begin
                    k_q <= cfg_kernel_rows;
                    c_q <= cfg_col_size;
                    r_q <= cfg_row_size;
                end
            end else begin
                if (accept_s) begin
                    if (col_last_s) begin
                        col_q <= {COL_W{1'b0}};
                        if (row_last_s) begin
                            frame_done_q <= 1'b1;
                        end else begin
                            row_q <= row_q + {{(ROW_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        col_q <= col_q + {{(COL_W-1){1'b0}}, 1'b1};
                    end
                end
                if (accept_s && emit_s) begin
                    win_valid_q  <= 1'b1;
                    win_data_q   <= win_data_d;
                    row_last_q   <= col_last_s;
                    frame_last_q <= col_last_s & row_last_s;
                end else if (out_accept_s) begin
                    win_valid_q  <= 1'b0;
                    row_last_q   <= 1'b0;
                    frame_last_q <= 1'b0;
                    if (frame_last_q) begin
                        busy_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign cfg_error         = cfg_error_q;
    assign busy              = busy_q;
    assign window_data       = win_data_q;
    assign window_valid      = win_valid_q;
    assign window_row_last   = row_last_q;
    assign window_frame_last = frame_last_q;
endmodule
